// File: rtl/clocked_rotor_stack_pkg.sv
// Shared definitions for the clocked rotor stack: FSM encoding, step mode
// constants and the default notch table (Enigma rotors I/II/III: Q, E, V).
package clocked_rotor_stack_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ADVANCE = 2'b01,
        HOLD    = 2'b10,
        ILLEGAL = 2'b11
    } rotor_state_t;

    localparam logic MODE_ODO    = 1'b0;
    localparam logic MODE_ENIGMA = 1'b1;

    localparam int DEFAULT_NUM_ROTORS = 3;
    localparam int DEFAULT_MODULUS    = 26;
    localparam int DEFAULT_POS_W      = 8;

    // Rotor 0 (fastest) lives in the least significant byte.
    localparam logic [23:0] DEFAULT_NOTCH = {8'd16, 8'd4, 8'd21};

endpackage

// File: rtl/clocked_rotor_stack_if.sv
// Control/status bundle of the rotor stack. The master drives load, step and
// mode; the slave (the stack) reports positions and step/wrap pulses.
interface clocked_rotor_stack_if #(
    parameter int NUM_ROTORS = 3,
    parameter int POS_W      = 8
);
    logic                          load;
    logic [NUM_ROTORS*POS_W-1:0]   init_pos;
    logic                          step;
    logic                          mode;
    logic [NUM_ROTORS*POS_W-1:0]   rotor_pos;
    logic                          step_done;
    logic                          wrap;
    logic [1:0]                    state;

    modport master (
        output load, init_pos, step, mode,
        input  rotor_pos, step_done, wrap, state
    );

    modport slave (
        input  load, init_pos, step, mode,
        output rotor_pos, step_done, wrap, state
    );
endinterface

// File: rtl/clocked_rotor_stack_rotor_step_logic.sv
// Combinational step decision for the rotor bank: which rotors advance on
// this step given the pre-step positions, plus an "every rotor at max" flag
// used to flag an odometer wrap.
module rotor_step_logic
    import clocked_rotor_stack_pkg::*;
#(
    parameter int                          NUM_ROTORS = DEFAULT_NUM_ROTORS,
    parameter int                          MODULUS    = DEFAULT_MODULUS,
    parameter int                          POS_W      = DEFAULT_POS_W,
    parameter logic [NUM_ROTORS*POS_W-1:0] NOTCH      = DEFAULT_NOTCH
) (
    input  logic [NUM_ROTORS*POS_W-1:0] pos,
    input  logic                        mode,
    output logic [NUM_ROTORS-1:0]       advance,
    output logic                        all_max
);
    localparam logic [POS_W-1:0] MAX_POS = POS_W'(MODULUS - 1);

    logic [NUM_ROTORS-1:0] is_max;
    logic [NUM_ROTORS-2:0] at_notch;
    logic [NUM_ROTORS-1:0] enigma_adv;
    logic [NUM_ROTORS:0]   carry;

    assign carry[0] = 1'b1;

    genvar k;
    for (k = 0; k < NUM_ROTORS; k++) begin : g_rotor
        assign is_max[k]  = (pos[k*POS_W +: POS_W] == MAX_POS);
        assign carry[k+1] = carry[k] & is_max[k];

        // The slowest rotor's notch never moves anything, so it is not decoded.
        if (k < NUM_ROTORS - 1) begin : g_notch
            assign at_notch[k] = (pos[k*POS_W +: POS_W] == NOTCH[k*POS_W +: POS_W]);
        end

        // Middle rotors also step themselves when sitting on their own notch
        // (the Enigma double-step anomaly); the slowest rotor does not.
        if (k == 0) begin : g_fast
            assign enigma_adv[k] = 1'b1;
        end else if (k <= NUM_ROTORS - 2) begin : g_mid
            assign enigma_adv[k] = at_notch[k-1] | at_notch[k];
        end else begin : g_slow
            assign enigma_adv[k] = at_notch[k-1];
        end

        assign advance[k] = (mode == MODE_ENIGMA) ? enigma_adv[k] : carry[k];
    end

    assign all_max = carry[NUM_ROTORS];

endmodule

// File: rtl/clocked_rotor_stack.sv
// Clocked bank of modulo-MODULUS rotors. One rising edge of step advances the
// bank exactly once, either as an odometer or with Enigma notch stepping.
module clocked_rotor_stack
    import clocked_rotor_stack_pkg::*;
#(
    parameter int                          NUM_ROTORS = DEFAULT_NUM_ROTORS,
    parameter int                          MODULUS    = DEFAULT_MODULUS,
    parameter int                          POS_W      = DEFAULT_POS_W,
    parameter logic [NUM_ROTORS*POS_W-1:0] NOTCH      = DEFAULT_NOTCH
) (
    input  logic                  clk,
    input  logic                  resetn,
    clocked_rotor_stack_if.slave  bus
);
    localparam int               W       = NUM_ROTORS * POS_W;
    localparam logic [POS_W-1:0] MAX_POS = POS_W'(MODULUS - 1);
    localparam logic [POS_W-1:0] ONE     = POS_W'(1);
    localparam logic [POS_W:0]   MOD_EXT = (POS_W + 1)'(MODULUS);

    rotor_state_t          state_q;
    logic [W-1:0]          rotor_pos_q;
    logic                  step_done_q;
    logic                  wrap_q;
    logic                  step_d;
    logic                  armed;
    logic                  rise;
    logic [NUM_ROTORS-1:0] advance;
    logic                  all_max;
    logic [W-1:0]          next_pos;
    logic [W-1:0]          load_pos;

    rotor_step_logic #(
        .NUM_ROTORS (NUM_ROTORS),
        .MODULUS    (MODULUS),
        .POS_W      (POS_W),
        .NOTCH      (NOTCH)
    ) u_step (
        .pos     (rotor_pos_q),
        .mode    (bus.mode),
        .advance (advance),
        .all_max (all_max)
    );

    // A key already down when reset releases must be let go before it counts,
    // hence the extra armed qualifier alongside the edge detector.
    assign rise = bus.step & ~step_d & armed;

    genvar k;
    for (k = 0; k < NUM_ROTORS; k++) begin : g_pos
        logic [POS_W-1:0] p;
        logic [POS_W-1:0] init;
        assign p    = rotor_pos_q[k*POS_W +: POS_W];
        assign init = bus.init_pos[k*POS_W +: POS_W];
        assign next_pos[k*POS_W +: POS_W] = !advance[k]    ? p
                                          : (p == MAX_POS) ? '0
                                          : p + ONE;
        assign load_pos[k*POS_W +: POS_W] = ({1'b0, init} < MOD_EXT) ? init : '0;
    end

    // Step FSM, edge detector and registered position/pulse outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rotor_pos_q <= '0;
            step_done_q <= 1'b0;
            wrap_q      <= 1'b0;
            step_d      <= 1'b0;
            armed       <= 1'b0;
        end else begin
            step_d      <= bus.step;
            armed       <= armed | ~bus.step;
            step_done_q <= 1'b0;
            wrap_q      <= 1'b0;
            if (bus.load) begin
                state_q     <= IDLE;
                rotor_pos_q <= load_pos;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) state_q <= ADVANCE;
                    end
                    ADVANCE: begin
                        rotor_pos_q <= next_pos;
                        step_done_q <= 1'b1;
                        wrap_q      <= (bus.mode == MODE_ODO) & all_max;
                        state_q     <= HOLD;
                    end
                    HOLD: begin
                        if (!bus.step) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.rotor_pos = rotor_pos_q;
    assign bus.step_done = step_done_q;
    assign bus.wrap      = wrap_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_clocked_rotor_stack.sv
// Scoreboard bench for clocked_rotor_stack: each press pushes its expected
// positions/wrap; a negedge monitor pops and compares on every step_done.
module tb_clocked_rotor_stack;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_bad;
    int   wrap_seen;
    logic [24:0] exp_q[$];

    clocked_rotor_stack_if #(.NUM_ROTORS(3), .POS_W(8)) bus ();

    clocked_rotor_stack dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input int a2, input int a1, input int a0);
        logic [7:0] b2, b1, b0;
        b2 = 8'(a2);
        b1 = 8'(a1);
        b0 = 8'(a0);
        return {b2, b1, b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One 3-cycle key press: high for one sampled edge, then low for two.
    task automatic applyStimulus(input logic [23:0] exp_pos, input logic exp_wrap,
                                 input string name);
        exp_q.push_back({exp_pos, exp_wrap});
        bus.step = 1'b1;
        @(posedge clk); #1;
        bus.step = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic loadPos(input logic [23:0] init);
        bus.load     = 1'b1;
        bus.init_pos = init;
        @(posedge clk); #1;
        bus.load     = 1'b0;
    endtask

    // Monitor: every step_done must match the oldest outstanding expectation.
    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && bus.step_done === 1'b1) begin
                if (bus.wrap === 1'b1) wrap_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("[TB] FAIL sb_unexpected: got pos=%h wrap=%b expected no step_done",
                             bus.rotor_pos, bus.wrap);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rotor_pos, bus.wrap} !== e) begin
                        n_bad++;
                        $display("[TB] FAIL sb_step: got pos=%h wrap=%b expected pos=%h wrap=%b",
                                 bus.rotor_pos, bus.wrap, e[24:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        int v;
        int wraps_before;
        n_checks     = 0;
        n_bad        = 0;
        wrap_seen    = 0;
        resetn       = 1'b0;
        bus.load     = 1'b0;
        bus.init_pos = '0;
        bus.step     = 1'b0;
        bus.mode     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_pos", 32'(bus.rotor_pos), 32'd0);
        checkOutput("reset_state", 32'(bus.state), 32'd0);
        checkOutput("reset_done", 32'(bus.step_done), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // 1. Reset in the middle of ADVANCE, key still held at release.
        loadPos(pk(0, 0, 5));
        bus.step = 1'b1;
        @(posedge clk); #1;
        checkOutput("t1_in_advance", 32'(bus.state), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("t1_rst_pos", 32'(bus.rotor_pos), 32'd0);
        checkOutput("t1_rst_state", 32'(bus.state), 32'd0);
        checkOutput("t1_rst_done", 32'(bus.step_done), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t1_held_state", 32'(bus.state), 32'd0);
        checkOutput("t1_held_pos", 32'(bus.rotor_pos), 32'd0);
        bus.step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(pk(0, 0, 1), 1'b0, "t1_repress");

        // 2. Odometer carry and full wrap.
        bus.mode = 1'b0;
        loadPos(pk(0, 25, 25));
        applyStimulus(pk(1, 0, 0), 1'b0, "t2_carry");
        loadPos(pk(25, 25, 25));
        applyStimulus(pk(0, 0, 0), 1'b1, "t2_wrap");

        // 3. Enigma double-step from A,D,U.
        bus.mode = 1'b1;
        loadPos(pk(0, 3, 20));
        applyStimulus(pk(0, 3, 21), 1'b0, "t3_adv");
        applyStimulus(pk(0, 4, 22), 1'b0, "t3_aew");
        applyStimulus(pk(1, 5, 23), 1'b0, "t3_bfx");

        // 4. Held key gives one advance; short pulses each give one.
        bus.mode = 1'b0;
        loadPos(pk(0, 0, 0));
        exp_q.push_back({pk(0, 0, 1), 1'b0});
        bus.step = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t4_hold_state", 32'(bus.state), 32'd2);
        checkOutput("t4_hold_drain", 32'(exp_q.size()), 32'd0);
        bus.step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 2; i <= 4; i++) begin
            exp_q.push_back({pk(0, 0, i), 1'b0});
            bus.step = 1'b1;
            @(posedge clk); #1;
            bus.step = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            checkOutput("t4_pulse_drain", 32'(exp_q.size()), 32'd0);
        end
        checkOutput("t4_pulse_pos", 32'(bus.rotor_pos), 32'(pk(0, 0, 4)));

        // 5. Load beats a simultaneous step rise, and cancels a pending ADVANCE.
        bus.load     = 1'b1;
        bus.init_pos = pk(7, 30, 2);
        bus.step     = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_load_pos", 32'(bus.rotor_pos), 32'(pk(7, 0, 2)));
        checkOutput("t5_load_state", 32'(bus.state), 32'd0);
        bus.step = 1'b0;
        @(posedge clk); #1;
        bus.step = 1'b1;
        @(posedge clk); #1;
        checkOutput("t5_in_advance", 32'(bus.state), 32'd1);
        bus.load     = 1'b1;
        bus.init_pos = pk(0, 0, 9);
        bus.step     = 1'b0;
        @(posedge clk); #1;
        bus.load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t5_drop_pos", 32'(bus.rotor_pos), 32'(pk(0, 0, 9)));
        checkOutput("t5_drop_state", 32'(bus.state), 32'd0);

        // 6. Full odometer cycle: 26**3 presses from zero.
        bus.mode = 1'b0;
        loadPos(pk(0, 0, 0));
        wraps_before = wrap_seen;
        for (int n = 0; n < 17576; n++) begin
            v = (n + 1) % 17576;
            applyStimulus(pk(v / 676, (v / 26) % 26, v % 26), (n == 17575), "t6_drain");
        end
        checkOutput("t6_wrap_count", 32'(wrap_seen - wraps_before), 32'd1);
        checkOutput("t6_final_pos", 32'(bus.rotor_pos), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
